alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter RESET_PSW, default 16'h0000, value loaded into the PSW register on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 inst  input  16  instruction word: [15:12] group, [11:8] op, [7] R/C, [6] W/B, [5:3] SRC/CON, [2:0] DST.
REQ-005 inst_valid  input  1  inst is presented.
REQ-006 inst_ready  output  1  block can accept inst this cycle.
REQ-007 done  output  1  one-cycle pulse when an instruction retires.
REQ-008 illegal  output  1  one-cycle pulse when an accepted instruction is not a legal ALU instruction.
REQ-009 alu_op1  output  16  ALU destination operand.
REQ-010 alu_op2  output  16  ALU source operand.
REQ-011 alu_instr  output  6  ALU operation code, {1'b0, op[3:0], W/B}.
REQ-012 alu_opt  output  1  ALU PSW-update enable.
REQ-013 alu_e  output  1  ALU execute strobe; the ALU acts on its rising edge.
REQ-014 alu_result  input  16  ALU result.
REQ-015 alu_psw  input  16  ALU PSW output.
REQ-016 psw  output  16  current PSW register, {.., V[4], S[3], N[2], Z[1], C[0]}.
REQ-017 dbg_sel  input  3  register-file debug read select.
REQ-018 dbg_data  output  16  R[dbg_sel], combinational.

Function
REQ-019 The block SHALL hold an 8x16 register file R0-R7 and a 16-bit PSW register; alu_psw SHALL feed PSW_i of the ALU via output psw.
REQ-020 Legal instruction: inst[15:12]==4'b0100 and op in 0..13; op order SHALL be ADD, ADDC, SUB, SUBC, DADD, CMP, XOR, AND, OR, BIT, BIC, BIS, SRA, RRC; op 14/15 or other group is illegal.
REQ-021 FSM states SHALL be IDLE, OPER, EXEC, SETTLE, WB; inst_ready SHALL equal (state==IDLE).
REQ-022 IDLE: on inst_valid&&inst_ready, the instruction SHALL be latched; legal -> OPER; illegal -> illegal pulses next cycle, state stays IDLE, no register or PSW change.
REQ-023 OPER: alu_op1=R[DST]; alu_op2=R[SRC] if R/C=0, else constant table CON 0..7 = 0, 1, 2, 4, 8, 16, 32, 16'hFFFF; alu_instr, alu_opt=1 driven; alu_e=0.
REQ-024 Operand and alu_instr outputs SHALL be registered and remain stable from OPER through WB.
REQ-025 EXEC: alu_e=1 for exactly one cycle; SETTLE: alu_e=0.
REQ-026 WB: PSW SHALL load alu_psw; R[DST] SHALL load alu_result (full 16 bits, byte ops included) except for CMP and BIT, which leave R[DST] unchanged; done SHALL pulse in the cycle after WB; next state IDLE.
REQ-027 Latency: accept at edge N, done high during cycle N+5; back-to-back throughput one instruction per 5 cycles.
REQ-028 inst_valid while inst_ready=0 SHALL be ignored (no queueing).
REQ-029 SRA/RRC SHALL ignore SRC/R/C; alu_op2 driven 0.
REQ-030 SRC==DST SHALL read the pre-instruction value for both operands.
REQ-031 done and illegal SHALL never be high in the same cycle.

Reset
REQ-032 On rst_n low, immediately: state=IDLE, R0-R7=0, psw=RESET_PSW, alu_e=0, alu_op1=alu_op2=0, alu_instr=0, alu_opt=0, done=0, illegal=0; inst_ready=1 while rst_n low.
REQ-033 Reset asserted mid-instruction SHALL abandon it with no register or PSW write, including when asserted during WB.

Verification
REQ-034 R1=5, R2=3, inst ADD R2,R1 (16'h4011) -> alu_op1=5, alu_op2=3, alu_instr=6'b000000, alu_e pulses once, R1=8, done at N+5.
REQ-035 R3=16'h0007, CMP #1,R3 (R/C=1, CON=1) -> alu_op2=1, alu_instr=6'b001010, R3 remains 7, psw=alu_psw.
REQ-036 inst=16'h4F00 (op 15) -> illegal pulses once, done stays 0, R0-R7 and psw unchanged, inst_ready remains 1.
REQ-037 Byte op ADD.B #-1,R4 with R4=16'h1200 -> alu_op2=16'hFFFF, alu_instr=6'b000001, R4 receives alu_result unchanged.
REQ-038 inst_valid held high with two queued-back instructions -> second accepted only when state returns to IDLE, exactly 5 cycles after the first.
REQ-039 rst_n driven low during SETTLE -> alu_e=0 and state=IDLE immediately, R[DST] unchanged, no done pulse.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: issue/sequencing block for a 16-bit two-operand ALU.
// Owns the R0-R7 register file and the PSW. Each accepted legal
// instruction runs through five states:
//   IDLE   -> OPER -> EXEC -> SETTLE -> WB -> IDLE
// Operands are registered at accept time. alu_e strobes during EXEC.
// PSW and R[DST] are written on the edge that leaves WB.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   inst, inst_valid       instruction input
//   inst_ready             high only in IDLE
//   done, illegal          one-cycle retire / reject pulses
//   alu_op1, alu_op2       ALU operands (dst, src)
//   alu_instr, alu_opt     ALU opcode {0, op, W/B} and PSW-update enable
//   alu_e                  ALU execute strobe
//   alu_result, alu_psw    values returned by the ALU
//   psw                    current PSW register, fed back to the ALU
//   dbg_sel, dbg_data      combinational register-file read port
module alu_issue #(
    parameter logic [15:0] RESET_PSW = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] inst,
    input  logic        inst_valid,
    output logic        inst_ready,
    output logic        done,
    output logic        illegal,
    output logic [15:0] alu_op1,
    output logic [15:0] alu_op2,
    output logic [5:0]  alu_instr,
    output logic        alu_opt,
    output logic        alu_e,
    input  logic [15:0] alu_result,
    input  logic [15:0] alu_psw,
    output logic [15:0] psw,
    input  logic [2:0]  dbg_sel,
    output logic [15:0] dbg_data
);

    typedef enum logic [2:0] {
        IDLE, OPER, EXEC, SETTLE, WB
    } state_t;

    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_BIT = 4'd9;
    localparam logic [3:0] OP_SRA = 4'd12;
    localparam logic [3:0] OP_RRC = 4'd13;

    state_t      state;
    logic [15:0] regs [8];
    logic [2:0]  dst_q;
    logic        wr_q;

    logic [3:0]  op;
    logic        legal;
    logic [15:0] con;
    logic [15:0] op2_nxt;

    assign op         = inst[11:8];
    assign legal      = (inst[15:12] == 4'b0100) && (op < 4'd14);
    assign inst_ready = (state == IDLE);
    assign dbg_data   = regs[dbg_sel];

    always_comb begin
        con = 16'h0000;
        case (inst[5:3])
            3'd0:    con = 16'h0000;
            3'd1:    con = 16'h0001;
            3'd2:    con = 16'h0002;
            3'd3:    con = 16'h0004;
            3'd4:    con = 16'h0008;
            3'd5:    con = 16'h0010;
            3'd6:    con = 16'h0020;
            default: con = 16'hFFFF;
        endcase
    end

    // Shifts are single-operand; keep the source bus quiet for them.
    always_comb begin
        op2_nxt = inst[7] ? con : regs[inst[5:3]];
        if (op == OP_SRA || op == OP_RRC)
            op2_nxt = 16'h0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            for (int i = 0; i < 8; i++)
                regs[i] <= 16'h0000;
            psw       <= RESET_PSW;
            alu_op1   <= 16'h0000;
            alu_op2   <= 16'h0000;
            alu_instr <= 6'd0;
            alu_opt   <= 1'b0;
            alu_e     <= 1'b0;
            done      <= 1'b0;
            illegal   <= 1'b0;
            dst_q     <= 3'd0;
            wr_q      <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            alu_e   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (inst_valid) begin
                        if (legal) begin
                            // Both operands sampled here, so SRC==DST
                            // sees the pre-instruction value.
                            alu_op1   <= regs[inst[2:0]];
                            alu_op2   <= op2_nxt;
                            alu_instr <= {1'b0, op, inst[6]};
                            alu_opt   <= 1'b1;
                            dst_q     <= inst[2:0];
                            wr_q      <= (op != OP_CMP) && (op != OP_BIT);
                            state     <= OPER;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                OPER: begin
                    alu_e <= 1'b1;
                    state <= EXEC;
                end
                EXEC: begin
                    state <= SETTLE;
                end
                SETTLE: begin
                    state <= WB;
                end
                WB: begin
                    psw <= alu_psw;
                    if (wr_q)
                        regs[dst_q] <= alu_result;
                    alu_opt <= 1'b0;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: table-driven and random checks of alu_issue against
// an architectural model of the register file and PSW.
module tb_alu_issue;

    localparam logic [15:0] RPSW = 16'h00A5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] inst = 16'h0000;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic        done;
    logic        illegal;
    logic [15:0] alu_op1;
    logic [15:0] alu_op2;
    logic [5:0]  alu_instr;
    logic        alu_opt;
    logic        alu_e;
    logic [15:0] alu_result = 16'h0000;
    logic [15:0] alu_psw = 16'h0000;
    logic [15:0] psw;
    logic [2:0]  dbg_sel = 3'd0;
    logic [15:0] dbg_data;

    alu_issue #(.RESET_PSW(RPSW)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst(inst), .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .done(done), .illegal(illegal),
        .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_instr(alu_instr), .alu_opt(alu_opt),
        .alu_e(alu_e),
        .alu_result(alu_result), .alu_psw(alu_psw),
        .psw(psw),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_r [8];
    logic [15:0] m_psw;
    logic [15:0] con_tab [8];

    logic [15:0] cap_op1;
    logic [15:0] cap_op2;
    logic [5:0]  cap_instr;

    typedef struct {
        logic [15:0] inst;
        logic [15:0] res;
        logic [15:0] pv;
        logic        chk;
        logic [15:0] e1;
        logic [15:0] e2;
        logic [5:0]  ei;
        logic [15:0] ed;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 8; r++) m_r[r] = 16'h0000;
        m_psw = RPSW;
    endtask

    // Uses 8ns of the 10ns low phase; call right at a negedge.
    task automatic check_regs();
        for (int r = 0; r < 8; r++) begin
            dbg_sel = r[2:0];
            #1;
            chk($sformatf("R%0d", r), dbg_data, m_r[r]);
        end
        chk("psw", psw, m_psw);
    endtask

    function automatic logic is_legal(input logic [15:0] i);
        return i[15:12] == 4'b0100 && i[11:8] <= 4'd13;
    endfunction

    // Called at the first negedge after the accepting edge.
    task automatic finish_inst(input logic [15:0] i);
        logic [3:0]  op;
        logic [15:0] e1, e2;
        logic [5:0]  ei;
        op = i[11:8];
        e1 = m_r[i[2:0]];
        if (op == 4'd12 || op == 4'd13) e2 = 16'h0000;
        else if (i[7]) e2 = con_tab[i[5:3]];
        else e2 = m_r[i[5:3]];
        ei = {1'b0, op, i[6]};
        if (!is_legal(i)) begin
            chk("illegal_pulse", {15'd0, illegal}, 16'd1);
            chk("illegal_nodone", {15'd0, done}, 16'd0);
            chk("illegal_ready", {15'd0, inst_ready}, 16'd1);
            check_regs();
        end else begin
            cap_op1 = alu_op1;
            cap_op2 = alu_op2;
            cap_instr = alu_instr;
            chk("oper_op1", alu_op1, e1);
            chk("oper_op2", alu_op2, e2);
            chk("oper_instr", {10'd0, alu_instr}, {10'd0, ei});
            chk("oper_opt", {15'd0, alu_opt}, 16'd1);
            chk("oper_e", {15'd0, alu_e}, 16'd0);
            chk("oper_ready", {15'd0, inst_ready}, 16'd0);
            chk("oper_illegal", {15'd0, illegal}, 16'd0);
            @(negedge clk);
            chk("exec_e", {15'd0, alu_e}, 16'd1);
            chk("exec_op1", alu_op1, e1);
            @(negedge clk);
            chk("settle_e", {15'd0, alu_e}, 16'd0);
            chk("settle_done", {15'd0, done}, 16'd0);
            @(negedge clk);
            chk("wb_e", {15'd0, alu_e}, 16'd0);
            chk("wb_done", {15'd0, done}, 16'd0);
            chk("wb_op2", alu_op2, e2);
            chk("wb_instr", {10'd0, alu_instr}, {10'd0, ei});
            chk("wb_ready", {15'd0, inst_ready}, 16'd0);
            @(negedge clk);
            chk("done_pulse", {15'd0, done}, 16'd1);
            chk("done_illegal", {15'd0, illegal}, 16'd0);
            chk("done_ready", {15'd0, inst_ready}, 16'd1);
            m_psw = alu_psw;
            if (op != 4'd5 && op != 4'd9) m_r[i[2:0]] = alu_result;
            check_regs();
        end
    endtask

    task automatic run_inst(input logic [15:0] i, input logic [15:0] res,
                            input logic [15:0] pv);
        chk("pre_ready", {15'd0, inst_ready}, 16'd1);
        inst = i;
        inst_valid = 1'b1;
        alu_result = res;
        alu_psw = pv;
        @(negedge clk);
        inst_valid = 1'b0;
        finish_inst(i);
        @(negedge clk);
        chk("post_done", {15'd0, done}, 16'd0);
        chk("post_illegal", {15'd0, illegal}, 16'd0);
    endtask

    task automatic abort_at(input int k);
        inst = 16'h4011;
        inst_valid = 1'b1;
        alu_result = 16'hBEEF;
        alu_psw = 16'h001F;
        @(negedge clk);
        inst_valid = 1'b0;
        repeat (k - 1) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_e", {15'd0, alu_e}, 16'd0);
        chk("abort_ready", {15'd0, inst_ready}, 16'd1);
        chk("abort_op1", alu_op1, 16'h0000);
        chk("abort_opt", {15'd0, alu_opt}, 16'd0);
        model_reset();
        #3;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("abort_nodone", {15'd0, done}, 16'd0);
        end
        check_regs();
    endtask

    initial begin
        con_tab = '{16'h0000, 16'h0001, 16'h0002, 16'h0004,
                    16'h0008, 16'h0010, 16'h0020, 16'hFFFF};
        vt[0]  = '{16'h4081, 16'h0005, 16'h0001, 1'b0, 0, 0, 0, 0};
        vt[1]  = '{16'h4082, 16'h0003, 16'h0002, 1'b0, 0, 0, 0, 0};
        vt[2]  = '{16'h4011, 16'h0008, 16'h0000, 1'b1,
                   16'h0005, 16'h0003, 6'b000000, 16'h0008};
        vt[3]  = '{16'h4083, 16'h0007, 16'h0000, 1'b0, 0, 0, 0, 0};
        vt[4]  = '{16'h458B, 16'hDEAD, 16'h0013, 1'b1,
                   16'h0007, 16'h0001, 6'b001010, 16'h0007};
        vt[5]  = '{16'h4084, 16'h1200, 16'h0000, 1'b0, 0, 0, 0, 0};
        vt[6]  = '{16'h40FC, 16'h12FF, 16'h0004, 1'b1,
                   16'h1200, 16'hFFFF, 6'b000001, 16'h12FF};
        vt[7]  = '{16'h4F00, 16'h5555, 16'h0008, 1'b0, 0, 0, 0, 0};
        vt[8]  = '{16'h4CFD, 16'h0900, 16'h0000, 1'b1,
                   16'h0000, 16'h0000, 6'b011001, 16'h0900};
        vt[9]  = '{16'h5011, 16'h7777, 16'h0010, 1'b0, 0, 0, 0, 0};
        vt[10] = '{16'h4609, 16'h0000, 16'h0002, 1'b1,
                   16'h0008, 16'h0008, 6'b001100, 16'h0000};
        vt[11] = '{16'h4E00, 16'h6666, 16'h0003, 1'b0, 0, 0, 0, 0};

        model_reset();
        #1;
        chk("rst_ready", {15'd0, inst_ready}, 16'd1);
        chk("rst_e", {15'd0, alu_e}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_illegal", {15'd0, illegal}, 16'd0);
        chk("rst_op1", alu_op1, 16'h0000);
        chk("rst_op2", alu_op2, 16'h0000);
        chk("rst_instr", {10'd0, alu_instr}, 16'd0);
        chk("rst_opt", {15'd0, alu_opt}, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_regs();

        for (int v = 0; v < 12; v++) begin
            run_inst(vt[v].inst, vt[v].res, vt[v].pv);
            if (vt[v].chk) begin
                chk($sformatf("vec%0d_op1", v), cap_op1, vt[v].e1);
                chk($sformatf("vec%0d_op2", v), cap_op2, vt[v].e2);
                chk($sformatf("vec%0d_instr", v),
                    {10'd0, cap_instr}, {10'd0, vt[v].ei});
                dbg_sel = vt[v].inst[2:0];
                #1;
                chk($sformatf("vec%0d_dst", v), dbg_data, vt[v].ed);
            end
        end

        // Valid held high: second instruction waits for IDLE.
        inst = 16'h4092;
        inst_valid = 1'b1;
        alu_result = 16'h1357;
        alu_psw = 16'h0009;
        @(negedge clk);
        inst = 16'h4813;
        finish_inst(16'h4092);
        alu_result = 16'h2468;
        alu_psw = 16'h0006;
        @(negedge clk);
        chk("b2b_done_low", {15'd0, done}, 16'd0);
        inst_valid = 1'b0;
        finish_inst(16'h4813);
        @(negedge clk);
        chk("b2b_post_ready", {15'd0, inst_ready}, 16'd1);

        for (int n = 0; n < 40; n++) begin
            logic [15:0] ri;
            ri = 16'($urandom);
            if ($urandom_range(3) != 0) ri[15:12] = 4'b0100;
            run_inst(ri, 16'($urandom), 16'($urandom));
        end

        abort_at(3);
        run_inst(16'h40BE, 16'hA5A5, 16'h0011);
        abort_at(4);
        run_inst(16'h4085, 16'h0042, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
